// File: rtl/layer_argmax_if.sv
// Handshake bundle between the last network layer and the argmax decision stage.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface layer_argmax_if #(
  parameter int DATAWIDTH  = 32,
  parameter int NUM_INPUTS = 1
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic                            in_valid;
  logic                            in_ready;
  logic [DATAWIDTH*NUM_INPUTS-1:0] in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [IDX_W-1:0]                out_index;
  logic [DATAWIDTH-1:0]            out_value;
  logic                            out_above;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_index, out_value, out_above
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_index, out_value, out_above
  );
endinterface

// File: rtl/layer_argmax.sv
// Serial argmax over a packed signed fixed-point vector, one element per clock,
// with a signed threshold flag on the winning value.
module layer_argmax #(
  parameter int                          DATAWIDTH  = 32,
  parameter int                          NUM_INPUTS = 1,
  parameter logic signed [DATAWIDTH-1:0] THRESHOLD  = 32'h0000_8000
) (
  input logic          clock,
  input logic          reset_n,
  layer_argmax_if.slave bus
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                      state_reg, state_next;
  logic signed [DATAWIDTH-1:0] in_elem  [NUM_INPUTS];
  logic signed [DATAWIDTH-1:0] vec_reg  [NUM_INPUTS];
  logic signed [DATAWIDTH-1:0] vec_next [NUM_INPUTS];
  logic [CNT_W-1:0]            cnt_reg, cnt_next;
  logic signed [DATAWIDTH-1:0] best_val_reg, best_val_next;
  logic [IDX_W-1:0]            best_idx_reg, best_idx_next;
  logic [IDX_W-1:0]            out_index_reg, out_index_next;
  logic signed [DATAWIDTH-1:0] out_value_reg, out_value_next;
  logic                        out_above_reg, out_above_next;
  logic signed [DATAWIDTH-1:0] cur_elem;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
      assign in_elem[gi] = bus.in_data[gi*DATAWIDTH +: DATAWIDTH];
    end
  endgenerate

  always_comb begin
    cur_elem = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (cnt_reg == CNT_W'(k)) cur_elem = vec_reg[k];
    end
  end

  always_comb begin
    state_next     = state_reg;
    vec_next       = vec_reg;
    cnt_next       = cnt_reg;
    best_val_next  = best_val_reg;
    best_idx_next  = best_idx_reg;
    out_index_next = out_index_reg;
    out_value_next = out_value_reg;
    out_above_next = out_above_reg;

    case (state_reg)
      IDLE: begin
        // in_ready is implied by being in IDLE
        if (bus.in_valid) begin
          vec_next      = in_elem;
          best_val_next = in_elem[0];
          best_idx_next = '0;
          cnt_next      = CNT_W'(1);
          state_next    = (NUM_INPUTS > 1) ? SCAN : DONE;
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest index among equal maxima
        if (cur_elem > best_val_reg) begin
          best_val_next = cur_elem;
          best_idx_next = cnt_reg[IDX_W-1:0];
        end
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if ((state_next == DONE) && (state_reg != DONE)) begin
      out_index_next = best_idx_next;
      out_value_next = best_val_next;
      out_above_next = (best_val_next >= THRESHOLD);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      best_val_reg  <= '0;
      best_idx_reg  <= '0;
      out_index_reg <= '0;
      out_value_reg <= '0;
      out_above_reg <= 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) vec_reg[k] <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      best_val_reg  <= best_val_next;
      best_idx_reg  <= best_idx_next;
      out_index_reg <= out_index_next;
      out_value_reg <= out_value_next;
      out_above_reg <= out_above_next;
      for (int k = 0; k < NUM_INPUTS; k++) vec_reg[k] <= vec_next[k];
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_index = out_index_reg;
  assign bus.out_value = out_value_reg;
  assign bus.out_above = out_above_reg;
endmodule

// File: doc/layer_argmax.md
Name: layer_argmax

Overview:
- Output-decision stage directly downstream of the last generated `layer`.
- Accepts that layer's packed signed fixed-point output vector through a valid/ready handshake.
- Scans the vector serially, one element per clock, and returns the index and value of the maximum element.
- Also returns a threshold flag, so a single-neuron network such as XOR gets its binary decision from the same block.

Parameters:
- DATAWIDTH, 32, width of one signed two's-complement fixed-point word (same format as `layer`).
- NUM_INPUTS, 1, number of elements in the vector (equals OUTPUT_NEURONS of the last layer); legal range is 1 or more.
- THRESHOLD, 32'h0000_8000, signed fixed-point decision threshold (0.5 with 16 fraction bits).
- IDX_W, max(1, $clog2(NUM_INPUTS)), width of the index output (localparam).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a vector
- in_data  input  DATAWIDTH*NUM_INPUTS  packed vector; element k = in_data[k*DATAWIDTH +: DATAWIDTH]
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- out_index  output  IDX_W  index of the maximum element
- out_value  output  DATAWIDTH  value of the maximum element
- out_above  output  1  1 when out_value >= THRESHOLD (signed compare)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While reset_n is low: state=IDLE, out_valid=0, out_index=0, out_value=0, out_above=0, and the scan counter and captured vector are cleared.
  - No transfer occurs while reset_n is low.
- in_ready = (state==IDLE), combinational from the state register; it does not depend on in_valid.
- FSM states: IDLE, SCAN, DONE.
  - IDLE, with in_valid & in_ready at the edge:
    - Capture the whole in_data into an internal register; best_val<=element 0, best_idx<=0, cnt<=1.
    - Next state is SCAN if NUM_INPUTS>1, otherwise DONE.
  - SCAN, each edge:
    - If $signed(element cnt) > $signed(best_val), update best_val and best_idx.
    - cnt<=cnt+1.
    - When the element just compared has index NUM_INPUTS-1, go to DONE.
  - DONE:
    - out_valid=1; out_index, out_value and out_above are registered and held stable until the handshake.
    - On out_valid & out_ready: out_valid<=0, go to IDLE.
    - Output data keeps its last value after the handshake.
- Latency: counting the accept edge as edge 1, out_valid goes high after edge NUM_INPUTS.
  - NUM_INPUTS=1: valid the cycle after the accept.
  - NUM_INPUTS=4: valid after 4 edges.
- Throughput: at best one vector per NUM_INPUTS+1 cycles, because in_ready is 0 in both SCAN and DONE.
- Tie rule: the comparison is strict, so among equal maxima the lowest index wins.
- Arithmetic:
  - All compares are signed at full DATAWIDTH; no rounding, no saturation.
  - out_above is computed from the final best_val when entering DONE.
- Backpressure: with out_ready=0 in DONE, the block holds indefinitely; in_data changes are ignored.
- Input stability: in_data only needs to be valid on the accept edge; later changes do not affect the result.
- Reset mid-scan or mid-DONE: the block aborts immediately to IDLE with all outputs cleared; no partial result is ever presented.
- Counter: cnt is IDX_W+1 bits wide and does not wrap during a scan.

Test Plan:
- Single-output XOR case: NUM_INPUTS=1, in_data=32'h0000_E666 (0.9) -> out_valid one cycle after accept, out_index=0, out_value=32'h0000_E666, out_above=1. Then in_data=32'h0000_1999 (0.1) -> out_above=0.
- Signed max with ties: NUM_INPUTS=4, elements {32'hFFFF_0000 (-1.0), 32'h0002_8000 (2.5), 32'h0002_8000 (2.5), 32'h0000_4000 (0.25)} -> out_valid after 4 edges, out_index=1, out_value=32'h0002_8000, out_above=1.
- All-negative vector: {32'hFFFF_0000, 32'hFFFF_8000, 32'hFFFE_0000, 32'hFFFF_C000} -> out_index=3, out_value=32'hFFFF_C000 (-0.25), out_above=0.
- Backpressure and busy: hold out_ready=0 for 10 cycles while toggling in_valid and in_data.
  - Outputs stay constant and in_ready stays 0.
  - Releasing out_ready gives exactly one handshake; in_ready=1 on the next cycle.
- Reset mid-scan: assert reset_n=0 two edges into a NUM_INPUTS=4 scan, asynchronously between edges.
  - Outputs clear immediately.
  - After release, a new vector {1.0, 0, 0, 0} yields out_index=0 with no stale result.
- Back-to-back vectors: hold in_valid=1 with a new vector presented each time in_ready=1 and out_ready=1 -> results arrive in order, one every NUM_INPUTS+1 cycles.
